apb_controller: RTL and testbench
=================================

Name: apb_controller

Overview:
- Downstream stage of the AHB slave interface in the AHB-to-APB bridge.
- Consumes the slave's Valid qualifier, pipelined addresses and write data (Haddr/Haddr1/Haddr2, Hwdata/Hdata1/Hdata2) and Hwrite/Hwrite_reg.
- Runs the APB two-phase SETUP/ENABLE protocol toward three APB peripherals, and drives Hreadyout and Hrdata back to the AHB side.
- Supports single and back-to-back pipelined writes and reads.

Parameters:
DATA_WIDTH, 32, width of Hwdata/Hdata1/Hdata2/Pwdata/Prdata/Hrdata

Ports:
Hclk  input  1  bridge clock; all state changes on the rising edge
Hreset  input  1  synchronous, active-high reset
Valid  input  1  AHB transfer qualifier from the slave interface
Hwrite  input  1  current AHB write strobe
Hwrite_reg  input  1  Hwrite delayed one cycle
Haddr  input  32  current AHB address
Haddr1  input  32  Haddr delayed 1 cycle
Haddr2  input  32  Haddr delayed 2 cycles
Hwdata  input  DATA_WIDTH  current AHB write data
Hdata1  input  DATA_WIDTH  Hwdata delayed 1 cycle
Prdata  input  DATA_WIDTH  APB read data
Pselx  output  3  one-hot APB peripheral select
Penable  output  1  APB enable phase
Pwrite  output  1  APB direction (1 = write)
Paddr  output  32  APB address
Pwdata  output  DATA_WIDTH  APB write data
Hreadyout  output  1  AHB ready back to master
Hrdata  output  DATA_WIDTH  AHB read data

Behaviour:
- Reset (Hreset=1 at a clock edge): state=ST_IDLE; Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hrdata=0, Hreadyout=1. Reset mid-transfer aborts immediately; there is no completion of the in-flight APB access.
- All outputs are registered: each value is computed from the current state and the transition taken, and appears one cycle after the decision.
- Pselx decode is internal, applied to the address being driven onto Paddr:
  - 0x8000_0000..0x83FF_FFFF -> 3'b001
  - 0x8400_0000..0x87FF_FFFF -> 3'b010
  - 0x8800_0000..0x8BFF_FFFF -> 3'b100
  - otherwise 3'b000 (the APB cycle still runs, with no peripheral selected).
- States: ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP.
- Transitions:
  - IDLE: Valid&Hwrite -> WWAIT; Valid&!Hwrite -> READ; else IDLE.
  - WWAIT: Valid -> WRITEP; else WRITE.
  - READ -> RENABLE.
  - WRITE: Valid -> WENABLEP; else WENABLE.
  - WRITEP -> WENABLEP.
  - RENABLE and WENABLE: Valid&Hwrite -> WWAIT; Valid&!Hwrite -> READ; else IDLE.
  - WENABLEP: !Hwrite_reg -> READ; Valid&Hwrite_reg -> WRITEP; !Valid&Hwrite_reg -> WRITE.
- Output rules by transition target:
  - Into READ: Paddr=Haddr; Pwrite=0; Pselx=decode; Penable=0; Hreadyout=0.
  - Into WWAIT or IDLE: Pselx=0; Penable=0; Hreadyout=1.
  - Into WRITE/WRITEP from WWAIT: Paddr=Haddr1; Pwdata=Hwdata; Pwrite=1; Pselx=decode; Penable=0; Hreadyout=0.
  - Into WRITE/WRITEP from WENABLEP: Paddr=Haddr2; Pwdata=Hdata1; Pwrite=1; Pselx=decode; Penable=0; Hreadyout=0.
  - Into RENABLE/WENABLE/WENABLEP: Penable=1; Pselx, Paddr, Pwrite, Pwdata held; Hreadyout=1.
- Read data: on the transition READ->RENABLE, Hrdata is not changed. In state RENABLE, Hrdata<=Prdata at the clock edge, so it is visible the cycle after the APB enable phase. Hrdata holds in all other states.
- Read timing: every APB access is exactly 2 cycles (setup, enable). A single read occupies IDLE->READ->RENABLE, with Hreadyout low for 1 cycle. A single write occupies IDLE->WWAIT->WRITE->WENABLE.
- Paddr/Pwdata/Pwrite hold their last values in IDLE; only Pselx and Penable return to 0.
- Valid is sampled only in the states that branch on it; Valid in READ/WRITEP is ignored.

Test Plan:
- Reset: assert Hreset for 2 cycles mid-write (state WRITE) -> next cycle Pselx=0, Penable=0, Hreadyout=1, state IDLE, Paddr=0.
- Single read: Valid=1, Hwrite=0, Haddr=0x8000_0010, Prdata=0xDEAD_BEEF -> cycle+1: Pselx=001, Paddr=0x8000_0010, Penable=0, Hreadyout=0; cycle+2: Penable=1, Hreadyout=1; cycle+3: Hrdata=0xDEAD_BEEF, Pselx=0.
- Single write: Valid=1, Hwrite=1, Haddr=0x8400_0004, next cycle Hwdata=0x1234_5678 -> APB setup with Pselx=010, Paddr=0x8400_0004, Pwdata=0x1234_5678, Pwrite=1, then Penable=1, then IDLE.
- Back-to-back writes to 0x8800_0000 and 0x8800_0004 (Valid held high) -> path WWAIT->WRITEP->WENABLEP->WRITE->WENABLE. The second APB setup carries Paddr=0x8800_0004 with the second data word, Pselx=100 on both accesses.
- Write followed by read: WENABLEP with Hwrite_reg=0 -> READ. Paddr equals the read address, Pwrite=0.
- Out-of-map read at Haddr=0x9000_0000 with Valid forced 1 -> APB cycle runs with Pselx=000, Hreadyout returns to 1 after 2 cycles.

Source files
------------

// File: rtl/apb_controller_if.sv
`default_nettype none
// ============================================================================
// apb_controller_if : AHB-slave-side inputs and APB/AHB-return outputs of the bridge controller
// Revision: 1.0
// ============================================================================
interface apb_controller_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Valid;
  logic                  Hwrite;
  logic                  Hwrite_reg;
  logic [31:0]           Haddr;
  logic [31:0]           Haddr1;
  logic [31:0]           Haddr2;
  logic [DATA_WIDTH-1:0] Hwdata;
  logic [DATA_WIDTH-1:0] Hdata1;
  logic [DATA_WIDTH-1:0] Prdata;
  logic [2:0]            Pselx;
  logic                  Penable;
  logic                  Pwrite;
  logic [31:0]           Paddr;
  logic [DATA_WIDTH-1:0] Pwdata;
  logic                  Hreadyout;
  logic [DATA_WIDTH-1:0] Hrdata;

  modport master (
    input  Valid, Hwrite, Hwrite_reg, Haddr, Haddr1, Haddr2, Hwdata, Hdata1, Prdata,
    output Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hrdata
  );

  modport slave (
    output Valid, Hwrite, Hwrite_reg, Haddr, Haddr1, Haddr2, Hwdata, Hdata1, Prdata,
    input  Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hrdata
  );
endinterface
`default_nettype wire

// File: rtl/apb_controller.sv
`default_nettype none
// ============================================================================
// apb_controller : APB SETUP/ENABLE sequencer of the AHB-to-APB bridge, fully registered outputs
// Revision: 1.0
// ============================================================================
module apb_controller #(
  parameter int DATA_WIDTH = 32
) (
  input  logic             Hclk,
  input  logic             Hreset,
  apb_controller_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            pselx_q, pselx_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [31:0]           paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  hreadyout_q, hreadyout_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

  // Three 64 MB windows starting at 0x8000_0000; anything else selects nobody.
  function automatic logic [2:0] decode(input logic [5:0] addr_hi);
    logic [2:0] sel;
    sel = 3'b000;
    case (addr_hi)
      6'b100000: sel = 3'b001;
      6'b100001: sel = 3'b010;
      6'b100010: sel = 3'b100;
      default:   sel = 3'b000;
    endcase
    return sel;
  endfunction

  always_comb begin
    state_d     = state_q;
    pselx_d     = pselx_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    hreadyout_d = hreadyout_q;
    hrdata_d    = hrdata_q;

    case (state_q)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (bus.Valid && bus.Hwrite)
          state_d = ST_WWAIT;
        else if (bus.Valid)
          state_d = ST_READ;
        else
          state_d = ST_IDLE;
      end
      ST_WWAIT:    state_d = bus.Valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     state_d = ST_RENABLE;
      ST_WRITE:    state_d = bus.Valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   state_d = ST_WENABLEP;
      ST_WENABLEP: begin
        if (!bus.Hwrite_reg)
          state_d = ST_READ;
        else if (bus.Valid)
          state_d = ST_WRITEP;
        else
          state_d = ST_WRITE;
      end
      default:     state_d = ST_IDLE;
    endcase

    // Outputs depend on where we are going, and for write setup also where we come from.
    case (state_d)
      ST_READ: begin
        paddr_d     = bus.Haddr;
        pwrite_d    = 1'b0;
        pselx_d     = decode(bus.Haddr[31:26]);
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
      end
      ST_IDLE, ST_WWAIT: begin
        pselx_d     = 3'b000;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
      end
      ST_WRITE, ST_WRITEP: begin
        // After a pipelined enable the address/data of the next write sit one stage deeper.
        if (state_q == ST_WENABLEP) begin
          paddr_d  = bus.Haddr2;
          pwdata_d = bus.Hdata1;
          pselx_d  = decode(bus.Haddr2[31:26]);
        end else begin
          paddr_d  = bus.Haddr1;
          pwdata_d = bus.Hwdata;
          pselx_d  = decode(bus.Haddr1[31:26]);
        end
        pwrite_d    = 1'b1;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
      end
      default: begin
        penable_d   = 1'b1;
        hreadyout_d = 1'b1;
      end
    endcase

    if (state_q == ST_RENABLE)
      hrdata_d = bus.Prdata;
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q     <= ST_IDLE;
      pselx_q     <= 3'b000;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'h0;
      pwdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      hreadyout_q <= hreadyout_d;
      hrdata_q    <= hrdata_d;
    end
  end

  assign bus.Pselx     = pselx_q;
  assign bus.Penable   = penable_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.Hreadyout = hreadyout_q;
  assign bus.Hrdata    = hrdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_controller.sv
`default_nettype none
// ============================================================================
// tb_apb_controller : scenario-driven scoreboard bench for the APB controller
// Revision: 1.0
// ============================================================================
module tb_apb_controller;

  typedef struct packed {
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hreadyout;
    logic [31:0] hrdata;
  } snap_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    passes = 0;
  snap_t exp_q[$];
  snap_t cur;
  snap_t rst_snap;

  apb_controller_if #(.DATA_WIDTH(32)) bus ();

  apb_controller #(.DATA_WIDTH(32)) dut (
    .Hclk   (clk),
    .Hreset (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Models the AHB slave's one- and two-stage delay registers.
  always @(posedge clk) begin
    bus.Haddr1     <= bus.Haddr;
    bus.Haddr2     <= bus.Haddr1;
    bus.Hdata1     <= bus.Hwdata;
    bus.Hwrite_reg <= bus.Hwrite;
  end

  task automatic step(input string name, input logic r, input logic v, input logic w,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] prd,
                      input snap_t e);
    snap_t got;
    snap_t want;
    rst        = r;
    bus.Valid  = v;
    bus.Hwrite = w;
    bus.Haddr  = a;
    bus.Hwdata = d;
    bus.Prdata = prd;
    exp_q.push_back(e);
    cur = e;
    @(posedge clk);
    @(negedge clk);
    got.pselx     = bus.Pselx;
    got.penable   = bus.Penable;
    got.pwrite    = bus.Pwrite;
    got.paddr     = bus.Paddr;
    got.pwdata    = bus.Pwdata;
    got.hreadyout = bus.Hreadyout;
    got.hrdata    = bus.Hrdata;
    want = exp_q.pop_front();
    checks++;
    if (got !== want)
      $display("FAIL %s: got pselx=%b pen=%b pwr=%b paddr=%h pwdata=%h rdy=%b hrdata=%h ; required pselx=%b pen=%b pwr=%b paddr=%h pwdata=%h rdy=%b hrdata=%h",
               name, got.pselx, got.penable, got.pwrite, got.paddr, got.pwdata, got.hreadyout, got.hrdata,
               want.pselx, want.penable, want.pwrite, want.paddr, want.pwdata, want.hreadyout, want.hrdata);
    else
      passes++;
  endtask

  task automatic test_reset();
    step("reset_cycle0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, rst_snap);
    step("reset_cycle1", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, rst_snap);
  endtask

  task automatic test_single_read();
    snap_t e;
    e = cur; e.pselx = 3'b001; e.paddr = 32'h8000_0010; e.pwrite = 1'b0; e.penable = 1'b0; e.hreadyout = 1'b0;
    step("rd_setup", 1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, e);
    e.penable = 1'b1; e.hreadyout = 1'b1;
    step("rd_enable", 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, e);
    e.pselx = 3'b000; e.penable = 1'b0; e.hrdata = 32'hDEAD_BEEF;
    step("rd_data", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, e);
  endtask

  task automatic test_single_write();
    snap_t e;
    e = cur; e.pselx = 3'b000; e.penable = 1'b0; e.hreadyout = 1'b1;
    step("wr_wwait", 1'b0, 1'b1, 1'b1, 32'h8400_0004, 32'h0, 32'h0, e);
    e.pselx = 3'b010; e.paddr = 32'h8400_0004; e.pwdata = 32'h1234_5678; e.pwrite = 1'b1; e.hreadyout = 1'b0;
    step("wr_setup", 1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 32'h0, e);
    e.penable = 1'b1; e.hreadyout = 1'b1;
    step("wr_enable", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, e);
    e.pselx = 3'b000; e.penable = 1'b0;
    step("wr_idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, e);
  endtask

  task automatic test_back_to_back_write();
    snap_t e;
    e = cur; e.pselx = 3'b000; e.penable = 1'b0; e.hreadyout = 1'b1;
    step("b2b_wwait", 1'b0, 1'b1, 1'b1, 32'h8800_0000, 32'h0, 32'h0, e);
    e.pselx = 3'b100; e.paddr = 32'h8800_0000; e.pwdata = 32'hA5A5_0001; e.pwrite = 1'b1; e.hreadyout = 1'b0;
    step("b2b_setup0", 1'b0, 1'b1, 1'b1, 32'h8800_0004, 32'hA5A5_0001, 32'h0, e);
    e.penable = 1'b1; e.hreadyout = 1'b1;
    step("b2b_enable0", 1'b0, 1'b0, 1'b1, 32'h0, 32'h5A5A_0002, 32'h0, e);
    e.penable = 1'b0; e.paddr = 32'h8800_0004; e.pwdata = 32'h5A5A_0002; e.hreadyout = 1'b0;
    step("b2b_setup1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, e);
    e.penable = 1'b1; e.hreadyout = 1'b1;
    step("b2b_enable1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, e);
    e.pselx = 3'b000; e.penable = 1'b0;
    step("b2b_idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, e);
  endtask

  task automatic test_write_then_read();
    snap_t e;
    e = cur; e.pselx = 3'b000; e.penable = 1'b0; e.hreadyout = 1'b1;
    step("wtr_wwait", 1'b0, 1'b1, 1'b1, 32'h8000_0020, 32'h0, 32'h0, e);
    e.pselx = 3'b001; e.paddr = 32'h8000_0020; e.pwdata = 32'h0F0F_1234; e.pwrite = 1'b1; e.hreadyout = 1'b0;
    step("wtr_wsetup", 1'b0, 1'b1, 1'b0, 32'h8400_0040, 32'h0F0F_1234, 32'h0, e);
    e.penable = 1'b1; e.hreadyout = 1'b1;
    step("wtr_wenable", 1'b0, 1'b1, 1'b0, 32'h8400_0040, 32'h0, 32'h0, e);
    e.pselx = 3'b010; e.paddr = 32'h8400_0040; e.pwrite = 1'b0; e.penable = 1'b0; e.hreadyout = 1'b0;
    step("wtr_rsetup", 1'b0, 1'b0, 1'b0, 32'h8400_0040, 32'h0, 32'hCAFE_F00D, e);
    e.penable = 1'b1; e.hreadyout = 1'b1;
    step("wtr_renable", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, e);
    e.pselx = 3'b000; e.penable = 1'b0; e.hrdata = 32'hCAFE_F00D;
    step("wtr_rdata", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, e);
  endtask

  task automatic test_back_to_back_read();
    snap_t e;
    e = cur; e.pselx = 3'b001; e.paddr = 32'h8000_0100; e.pwrite = 1'b0; e.penable = 1'b0; e.hreadyout = 1'b0;
    step("b2br_setup0", 1'b0, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 32'h0, e);
    e.penable = 1'b1; e.hreadyout = 1'b1;
    step("b2br_enable0", 1'b0, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 32'h1111_2222, e);
    e.pselx = 3'b100; e.paddr = 32'h8800_0200; e.penable = 1'b0; e.hreadyout = 1'b0; e.hrdata = 32'h1111_2222;
    step("b2br_setup1", 1'b0, 1'b1, 1'b0, 32'h8800_0200, 32'h0, 32'h1111_2222, e);
    e.penable = 1'b1; e.hreadyout = 1'b1;
    step("b2br_enable1", 1'b0, 1'b0, 1'b0, 32'h8800_0200, 32'h0, 32'h3333_4444, e);
    e.pselx = 3'b000; e.penable = 1'b0; e.hrdata = 32'h3333_4444;
    step("b2br_data1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h3333_4444, e);
  endtask

  task automatic test_out_of_map();
    snap_t e;
    e = cur; e.pselx = 3'b000; e.paddr = 32'h9000_0000; e.pwrite = 1'b0; e.penable = 1'b0; e.hreadyout = 1'b0;
    step("oom_setup", 1'b0, 1'b1, 1'b0, 32'h9000_0000, 32'h0, 32'h0BAD_0001, e);
    e.penable = 1'b1; e.hreadyout = 1'b1;
    step("oom_enable", 1'b0, 1'b0, 1'b0, 32'h9000_0000, 32'h0, 32'h0BAD_0001, e);
    e.penable = 1'b0; e.hrdata = 32'h0BAD_0001;
    step("oom_data", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BAD_0001, e);
  endtask

  task automatic test_reset_mid_write();
    snap_t e;
    e = cur; e.pselx = 3'b000; e.penable = 1'b0; e.hreadyout = 1'b1;
    step("rmw_wwait", 1'b0, 1'b1, 1'b1, 32'h8400_0100, 32'h0, 32'h0, e);
    e.pselx = 3'b010; e.paddr = 32'h8400_0100; e.pwdata = 32'h7777_8888; e.pwrite = 1'b1; e.hreadyout = 1'b0;
    step("rmw_setup", 1'b0, 1'b0, 1'b0, 32'h0, 32'h7777_8888, 32'h0, e);
    step("rmw_reset0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, rst_snap);
    step("rmw_reset1", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, rst_snap);
    step("rmw_idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, rst_snap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst_snap = '{pselx: 3'b000, penable: 1'b0, pwrite: 1'b0, paddr: 32'h0,
                 pwdata: 32'h0, hreadyout: 1'b1, hrdata: 32'h0};
    cur        = rst_snap;
    bus.Valid  = 1'b0;
    bus.Hwrite = 1'b0;
    bus.Haddr  = 32'h0;
    bus.Hwdata = 32'h0;
    bus.Prdata = 32'h0;
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back_write();
    test_write_then_read();
    test_back_to_back_read();
    test_out_of_map();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
